ninjakun_io_resp: RTL and testbench

NINJAKUN_IO_RESP -- requirements
Module: ninjakun_io_resp

---
 rtl/ninjakun_pkg.sv | 37 +++
 rtl/ninjakun_psgq.sv | 51 +++++
 rtl/ninjakun_io_resp.sv | 201 ++++++++++++++++++++
 tb/tb_ninjakun_io_resp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ninjakun_pkg.sv
// Shared constants and types for the Ninja-Kun I/O responder: address map,
// status bit positions and the PSG queue entry layout.
package ninjakun_pkg;

   // Read/write register addresses
   localparam logic [15:0] ADR_DSW1 = 16'hA000;
   localparam logic [15:0] ADR_DSW2 = 16'hA001;
   localparam logic [15:0] ADR_SCRX = 16'hA002;
   localparam logic [15:0] ADR_SCRY = 16'hA003;
   localparam logic [15:0] ADR_FLIP = 16'hA004;
   localparam logic [15:0] ADR_STAT = 16'hA005;

   // Window prefixes: PSG A010-A013 (upper 14 bits), palette C800-C9FF (upper 7 bits)
   localparam logic [13:0] ADR_PSG_HI = 14'(16'hA010 >> 2);
   localparam logic [6:0]  ADR_PAL_HI = 7'(16'hC800 >> 9);

   // Status byte layout {ovf,6'b0,qempty}
   localparam int unsigned STAT_OVF_BIT    = 7;
   localparam int unsigned STAT_QEMPTY_BIT = 0;

   localparam int unsigned PSG_ENTRY_W = 10;

   // One queued PSG access: {chip,addr/data} select plus the byte
   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] dat;
   } psg_entry_t;

   function automatic logic [7:0] status_byte(input logic ovf, input logic qempty);
      logic [7:0] s;
      s                  = 8'h00;
      s[STAT_OVF_BIT]    = ovf;
      s[STAT_QEMPTY_BIT] = qempty;
      return s;
   endfunction

endpackage

// File: rtl/ninjakun_psgq.sv
// Synchronous FIFO buffering CPU writes to the PSGs until the next 3 MHz slot.
// Push to a full queue is accepted only when a pop happens in the same cycle.
module ninjakun_psgq
   import ninjakun_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         push_i,
   input  logic [PSG_ENTRY_W-1:0]       wdata_i,
   input  logic                         pop_i,
   output logic [PSG_ENTRY_W-1:0]       rdata_c,
   output logic                         full_c,
   output logic                         empty_c,
   output logic [$clog2(DEPTH):0]       count_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PSG_ENTRY_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]          wptr_q, rptr_q;
   logic [CW-1:0]          count_q;
   logic                   do_push_c, do_pop_c;

   assign empty_c   = (count_q == '0);
   assign full_c    = (count_q == CW'(DEPTH));
   assign do_pop_c  = pop_i & ~empty_c;
   assign do_push_c = push_i & (~full_c | do_pop_c);
   assign rdata_c   = mem_q[rptr_q];
   assign count_o   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push_c) wptr_q <= wptr_q + PW'(1);
         if (do_pop_c)  rptr_q <= rptr_q + PW'(1);
         count_q <= count_q + CW'(do_push_c) - CW'(do_pop_c);
      end
   end

   // Storage needs no reset; occupancy decides what is valid
   always_ff @(posedge clk_i) begin
      if (do_push_c) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/ninjakun_io_resp.sv
// Ninja-Kun shared-bus I/O responder: DIP/status reads, scroll/flip registers,
// palette write strobe and a queued PSG write port.
// Define NINJAKUN_IORESP_SCRDBUF_EN to latch scroll shadows into the active
// scroll outputs only on the VBLK rising edge.
module ninjakun_io_resp
   import ninjakun_pkg::*;
#(
   parameter int unsigned PSGQ_DEPTH = 4,
   parameter logic [7:0]  SCR_RST    = 8'h00
) (
   input  logic        CLK24M,
   input  logic        RESET,
   input  logic        CE3M,
   input  logic        VBLK,
   input  logic [15:0] CPADR,
   input  logic [7:0]  CPODT,
   output logic [7:0]  CPIDT,
   input  logic        CPRED,
   input  logic        CPWRT,
   input  logic [7:0]  DSW1,
   input  logic [7:0]  DSW2,
   output logic [7:0]  SCRPX,
   output logic [7:0]  SCRPY,
   output logic        FLIP,
   output logic        PALWE,
   output logic [8:0]  PALAD,
   output logic [7:0]  PALDT,
   output logic        PSGWE,
   output logic [1:0]  PSGSEL,
   output logic [7:0]  PSGDT
);
   localparam int unsigned CNT_W = $clog2(PSGQ_DEPTH) + 1;

   logic       wrt_q, rd_q, vblk_q;
   logic [7:0] cpidt_q, cpidt_d;
   logic [7:0] scrx_q, scrx_d, scry_q, scry_d;
   logic [7:0] scrpx_q, scrpx_d, scrpy_q, scrpy_d;
   logic       flip_q, flip_d;
   logic       palwe_q, palwe_d;
   logic [8:0] palad_q, palad_d;
   logic [7:0] paldt_q, paldt_d;
   logic       psgwe_q, psgwe_d;
   logic [1:0] psgsel_q, psgsel_d;
   logic [7:0] psgdt_q, psgdt_d;
   logic       ovf_q, ovf_d;

   logic                   wr_rise_c, rd_rise_c, vblk_rise_c;
   logic                   psg_hit_c, pal_hit_c;
   logic                   q_push_c, q_pop_c, q_full_c, q_empty_c;
   logic [PSG_ENTRY_W-1:0] q_rdata_c;
   logic [CNT_W-1:0]       q_count;
   psg_entry_t             q_wdata_c, q_head_c;
   logic [7:0]             rd_data_c;

   assign wr_rise_c   = CPWRT & ~wrt_q;
   assign rd_rise_c   = CPRED & ~rd_q;
   assign vblk_rise_c = VBLK & ~vblk_q;
   assign psg_hit_c   = (CPADR[15:2] == ADR_PSG_HI);
   assign pal_hit_c   = (CPADR[15:9] == ADR_PAL_HI);
   assign q_push_c    = wr_rise_c & psg_hit_c;
   assign q_pop_c     = CE3M & ~q_empty_c;
   assign q_wdata_c   = psg_entry_t'{sel: CPADR[1:0], dat: CPODT};
   assign q_head_c    = psg_entry_t'(q_rdata_c);

   ninjakun_psgq #(.DEPTH(PSGQ_DEPTH)) u_psgq (
      .clk_i   (CLK24M),
      .rst_n_i (RESET),
      .push_i  (q_push_c),
      .wdata_i (q_wdata_c),
      .pop_i   (q_pop_c),
      .rdata_c (q_rdata_c),
      .full_c  (q_full_c),
      .empty_c (q_empty_c),
      .count_o (q_count)
   );

   // Read decode; unmapped addresses float high
   always_comb begin
      rd_data_c = 8'hFF;
      case (CPADR)
         ADR_DSW1: rd_data_c = DSW1;
         ADR_DSW2: rd_data_c = DSW2;
         ADR_SCRX: rd_data_c = scrx_q;
         ADR_SCRY: rd_data_c = scry_q;
         ADR_FLIP: rd_data_c = {7'b0, flip_q};
         ADR_STAT: rd_data_c = status_byte(ovf_q, q_count == '0);
         default:  rd_data_c = 8'hFF;
      endcase
   end

   // Next-state for bus registers, strobes and overflow flag
   always_comb begin
      cpidt_d  = cpidt_q;
      scrx_d   = scrx_q;
      scry_d   = scry_q;
      scrpx_d  = scrpx_q;
      scrpy_d  = scrpy_q;
      flip_d   = flip_q;
      palwe_d  = 1'b0;
      palad_d  = palad_q;
      paldt_d  = paldt_q;
      psgwe_d  = 1'b0;
      psgsel_d = psgsel_q;
      psgdt_d  = psgdt_q;
      ovf_d    = ovf_q;

      if (CPRED) cpidt_d = rd_data_c;

      // Frame-boundary copy; a shadow write on this same edge lands next frame.
      // Without double buffering shadows already equal the outputs, so this is idle.
      if (vblk_rise_c) begin
         scrpx_d = scrx_q;
         scrpy_d = scry_q;
      end

      if (wr_rise_c) begin
         case (CPADR)
            ADR_SCRX: begin
               scrx_d = CPODT;
`ifndef NINJAKUN_IORESP_SCRDBUF_EN
               scrpx_d = CPODT;
`endif
            end
            ADR_SCRY: begin
               scry_d = CPODT;
`ifndef NINJAKUN_IORESP_SCRDBUF_EN
               scrpy_d = CPODT;
`endif
            end
            ADR_FLIP: flip_d = CPODT[0];
            default:  ;
         endcase
         if (pal_hit_c) begin
            palwe_d = 1'b1;
            palad_d = CPADR[8:0];
            paldt_d = CPODT;
         end
      end

      if (q_pop_c) begin
         psgwe_d  = 1'b1;
         psgsel_d = q_head_c.sel;
         psgdt_d  = q_head_c.dat;
      end

      // Clear on status read edge; a same-cycle overflow takes priority
      if (rd_rise_c && (CPADR == ADR_STAT)) ovf_d = 1'b0;
      if (q_push_c && q_full_c && !q_pop_c)  ovf_d = 1'b1;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLK24M) begin
      if (!RESET) begin
         wrt_q    <= 1'b0;
         rd_q     <= 1'b0;
         vblk_q   <= 1'b0;
         cpidt_q  <= 8'hFF;
         scrx_q   <= SCR_RST;
         scry_q   <= SCR_RST;
         scrpx_q  <= SCR_RST;
         scrpy_q  <= SCR_RST;
         flip_q   <= 1'b0;
         palwe_q  <= 1'b0;
         palad_q  <= '0;
         paldt_q  <= '0;
         psgwe_q  <= 1'b0;
         psgsel_q <= '0;
         psgdt_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wrt_q    <= CPWRT;
         rd_q     <= CPRED;
         vblk_q   <= VBLK;
         cpidt_q  <= cpidt_d;
         scrx_q   <= scrx_d;
         scry_q   <= scry_d;
         scrpx_q  <= scrpx_d;
         scrpy_q  <= scrpy_d;
         flip_q   <= flip_d;
         palwe_q  <= palwe_d;
         palad_q  <= palad_d;
         paldt_q  <= paldt_d;
         psgwe_q  <= psgwe_d;
         psgsel_q <= psgsel_d;
         psgdt_q  <= psgdt_d;
         ovf_q    <= ovf_d;
      end
   end

   assign CPIDT  = cpidt_q;
   assign SCRPX  = scrpx_q;
   assign SCRPY  = scrpy_q;
   assign FLIP   = flip_q;
   assign PALWE  = palwe_q;
   assign PALAD  = palad_q;
   assign PALDT  = paldt_q;
   assign PSGWE  = psgwe_q;
   assign PSGSEL = psgsel_q;
   assign PSGDT  = psgdt_q;

endmodule

// File: tb/tb_ninjakun_io_resp.sv
// Bench for ninjakun_io_resp: directed bus scenarios plus a randomized PSG
// queue run against a queue-based reference model.
module tb_ninjakun_io_resp;
   localparam int unsigned DEPTH     = 4;
   localparam logic [7:0]  SCR_RST_V = 8'h5C;

   logic        clk = 1'b0;
   logic        RESET, CE3M, VBLK, CPRED, CPWRT;
   logic [15:0] CPADR;
   logic [7:0]  CPODT, DSW1, DSW2;
   logic [7:0]  CPIDT, SCRPX, SCRPY, PALDT, PSGDT;
   logic        FLIP, PALWE, PSGWE;
   logic [8:0]  PALAD;
   logic [1:0]  PSGSEL;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ninjakun_io_resp #(.PSGQ_DEPTH(DEPTH), .SCR_RST(SCR_RST_V)) dut (
      .CLK24M(clk), .RESET(RESET), .CE3M(CE3M), .VBLK(VBLK),
      .CPADR(CPADR), .CPODT(CPODT), .CPIDT(CPIDT), .CPRED(CPRED), .CPWRT(CPWRT),
      .DSW1(DSW1), .DSW2(DSW2), .SCRPX(SCRPX), .SCRPY(SCRPY), .FLIP(FLIP),
      .PALWE(PALWE), .PALAD(PALAD), .PALDT(PALDT),
      .PSGWE(PSGWE), .PSGSEL(PSGSEL), .PSGDT(PSGDT)
   );

   // Strobe monitors sampled mid-cycle
   int unsigned pal_cnt = 0;
   logic [8:0]  pal_ad_last = '0;
   logic [7:0]  pal_dt_last = '0;
   logic [9:0]  psg_obs[$];
   always @(negedge clk) begin
      if (PALWE === 1'b1) begin
         pal_cnt     = pal_cnt + 1;
         pal_ad_last = PALAD;
         pal_dt_last = PALDT;
      end
      if (PSGWE === 1'b1) psg_obs.push_back({PSGSEL, PSGDT});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b0; CPWRT = 1'b0; CPRED = 1'b0; CE3M = 1'b0; VBLK = 1'b0;
      step(); step();
      RESET = 1'b1;
      step();
   endtask

   task automatic read_byte(input logic [15:0] a, output logic [7:0] d);
      CPADR = a; CPRED = 1'b1;
      step();
      d = CPIDT;
      CPRED = 1'b0;
      step();
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] v, input int hold);
      CPADR = a; CPODT = v; CPWRT = 1'b1;
      repeat (hold) step();
      CPWRT = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [7:0] d;
      RESET = 1'b0; CE3M = 1'b0; VBLK = 1'b0; CPRED = 1'b0; CPWRT = 1'b0;
      CPADR = 16'h0000; CPODT = 8'h00; DSW1 = 8'h00; DSW2 = 8'h00;
      step(); step();
      n_total++; if (CPIDT !== 8'hFF) $display("FAIL reset_cpidt got %h want FF", CPIDT); else n_pass++;
      n_total++; if ({SCRPX, SCRPY} !== {SCR_RST_V, SCR_RST_V})
         $display("FAIL reset_scroll got %h want %h", {SCRPX, SCRPY}, {SCR_RST_V, SCR_RST_V}); else n_pass++;
      n_total++; if ({FLIP, PALWE, PALAD, PALDT} !== 19'h0)
         $display("FAIL reset_pal_flip got %h want 0", {FLIP, PALWE, PALAD, PALDT}); else n_pass++;
      n_total++; if ({PSGWE, PSGSEL, PSGDT} !== 11'h0)
         $display("FAIL reset_psg got %h want 0", {PSGWE, PSGSEL, PSGDT}); else n_pass++;
      RESET = 1'b1;
      step();
      read_byte(16'hA005, d);
      n_total++; if (d !== 8'h01) $display("FAIL reset_status got %h want 01", d); else n_pass++;
   endtask

   task automatic test_read();
      logic [7:0] d, sw2;
      logic [15:0] a;
      do_reset();
      sw2 = 8'($urandom);
      DSW1 = 8'h5A; DSW2 = sw2;
      read_byte(16'hA000, d);
      n_total++; if (d !== 8'h5A) $display("FAIL read_dsw1 got %h want 5A", d); else n_pass++;
      read_byte(16'hA0FF, d);
      n_total++; if (d !== 8'hFF) $display("FAIL read_a0ff got %h want FF", d); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom);
         if (a >= 16'hA000 && a <= 16'hA005) a = 16'h1234;
         read_byte(a, d);
         n_total++; if (d !== 8'hFF) $display("FAIL read_unmapped %h got %h want FF", a, d); else n_pass++;
      end
      read_byte(16'hA001, d);
      n_total++; if (d !== sw2) $display("FAIL read_dsw2 got %h want %h", d, sw2); else n_pass++;
      CPADR = 16'hA0FF; DSW2 = ~sw2;
      step(); step();
      n_total++; if (CPIDT !== sw2) $display("FAIL read_hold got %h want %h", CPIDT, sw2); else n_pass++;
   endtask

   task automatic test_psg_single();
      int base;
      logic [7:0] d;
      do_reset();
      base = psg_obs.size();
      bus_write(16'hA010, 8'h3C, 8);
      n_total++; if (psg_obs.size() != base) $display("FAIL psg_early got %0d want 0", psg_obs.size() - base); else n_pass++;
      CE3M = 1'b1;
      repeat (4) step();
      CE3M = 1'b0;
      step();
      n_total++; if (psg_obs.size() != base + 1) $display("FAIL psg_single_count got %0d want 1", psg_obs.size() - base); else n_pass++;
      if (psg_obs.size() == base + 1) begin
         n_total++; if (psg_obs[base] !== 10'h03C) $display("FAIL psg_single_entry got %h want 03C", psg_obs[base]); else n_pass++;
      end
      read_byte(16'hA005, d);
      n_total++; if (d !== 8'h01) $display("FAIL psg_single_status got %h want 01", d); else n_pass++;
   endtask

   task automatic test_overflow();
      int base;
      logic [7:0] dv[5];
      logic [7:0] d;
      do_reset();
      base = psg_obs.size();
      for (int i = 0; i < 5; i++) begin
         dv[i] = 8'($urandom);
         bus_write(16'hA010 + 16'(i % 4), dv[i], 2);
      end
      for (int i = 0; i < 40; i++) begin
         CE3M = (i % 8 == 0);
         step();
      end
      CE3M = 1'b0;
      step();
      n_total++; if (psg_obs.size() != base + 4) $display("FAIL ovf_pop_count got %0d want 4", psg_obs.size() - base); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (psg_obs.size() > base + i) begin
            n_total++;
            if (psg_obs[base + i] !== {2'(i), dv[i]})
               $display("FAIL ovf_entry%0d got %h want %h", i, psg_obs[base + i], {2'(i), dv[i]});
            else n_pass++;
         end
      end
      read_byte(16'hA005, d);
      n_total++; if (d !== 8'h81) $display("FAIL ovf_status got %h want 81", d); else n_pass++;
      read_byte(16'hA005, d);
      n_total++; if (d !== 8'h01) $display("FAIL ovf_reread got %h want 01", d); else n_pass++;
   endtask

   task automatic test_scroll();
      logic [7:0] d, ex_x, ex_y;
      do_reset();
      CPADR = 16'hA002; CPODT = 8'h40; CPWRT = 1'b1;
      step();
`ifdef NINJAKUN_IORESP_SCRDBUF_EN
      ex_x = SCR_RST_V;
`else
      ex_x = 8'h40;
`endif
      n_total++; if (SCRPX !== ex_x) $display("FAIL scrx_after_write got %h want %h", SCRPX, ex_x); else n_pass++;
      CPWRT = 1'b0;
      repeat (3) step();
      n_total++; if (SCRPX !== ex_x) $display("FAIL scrx_mid_frame got %h want %h", SCRPX, ex_x); else n_pass++;
      VBLK = 1'b1;
      step();
      n_total++; if (SCRPX !== 8'h40) $display("FAIL scrx_vblk got %h want 40", SCRPX); else n_pass++;
      VBLK = 1'b0;
      step();
      // Shadow write on the same edge as VBLK rising
      CPADR = 16'hA003; CPODT = 8'h55; CPWRT = 1'b1; VBLK = 1'b1;
      step();
`ifdef NINJAKUN_IORESP_SCRDBUF_EN
      ex_y = SCR_RST_V;
`else
      ex_y = 8'h55;
`endif
      n_total++; if (SCRPY !== ex_y) $display("FAIL scry_same_edge got %h want %h", SCRPY, ex_y); else n_pass++;
      CPWRT = 1'b0; VBLK = 1'b0;
      step();
      VBLK = 1'b1;
      step();
      n_total++; if (SCRPY !== 8'h55) $display("FAIL scry_next_frame got %h want 55", SCRPY); else n_pass++;
      VBLK = 1'b0;
      read_byte(16'hA003, d);
      n_total++; if (d !== 8'h55) $display("FAIL scry_readback got %h want 55", d); else n_pass++;
      bus_write(16'hA004, 8'h03, 3);
      n_total++; if (FLIP !== 1'b1) $display("FAIL flip_set got %b want 1", FLIP); else n_pass++;
      read_byte(16'hA004, d);
      n_total++; if (d !== 8'h01) $display("FAIL flip_readback got %h want 01", d); else n_pass++;
      bus_write(16'hA004, 8'hFE, 2);
      n_total++; if (FLIP !== 1'b0) $display("FAIL flip_clear got %b want 0", FLIP); else n_pass++;
   endtask

   task automatic test_pal();
      int unsigned base;
      logic [7:0] v;
      do_reset();
      base = pal_cnt;
      bus_write(16'hC9FF, 8'h77, 6);
      n_total++; if (pal_cnt != base + 1) $display("FAIL pal_pulse_count got %0d want 1", pal_cnt - base); else n_pass++;
      n_total++; if ({pal_ad_last, pal_dt_last} !== {9'h1FF, 8'h77})
         $display("FAIL pal_c9ff got %h/%h want 1FF/77", pal_ad_last, pal_dt_last); else n_pass++;
      v = 8'($urandom);
      bus_write(16'hC800, v, 2);
      n_total++; if ({pal_ad_last, pal_dt_last} !== {9'h000, v})
         $display("FAIL pal_c800 got %h/%h want 000/%h", pal_ad_last, pal_dt_last, v); else n_pass++;
      base = pal_cnt;
      bus_write(16'hCA00, 8'h11, 2);
      bus_write(16'hC7FF, 8'h22, 2);
      n_total++; if (pal_cnt != base) $display("FAIL pal_outside got %0d want 0", pal_cnt - base); else n_pass++;
   endtask

   task automatic test_random();
      logic [9:0] q[$];
      logic       m_ovf, prev_wrt, exp_we, pop, rise;
      logic [9:0] exp_ent;
      logic [7:0] d;
      int         pre, off;
      do_reset();
      m_ovf = 1'b0; prev_wrt = 1'b0; exp_ent = '0;
      for (int i = 0; i < 400 + DEPTH + 2; i++) begin
         off = $urandom_range(0, 4);
         CPADR = 16'hA010 + 16'(off);
         CPODT = 8'($urandom);
         if (i < 400) begin
            CPWRT = 1'($urandom_range(0, 1));
            CE3M  = ($urandom_range(0, 2) == 0);
         end else begin
            CPWRT = 1'b0;
            CE3M  = 1'b1;
         end
         step();
         pre  = q.size();
         pop  = CE3M && (pre > 0);
         rise = CPWRT && !prev_wrt;
         prev_wrt = CPWRT;
         exp_we = pop;
         if (pop) exp_ent = q.pop_front();
         if (rise && off < 4) begin
            if (pre < DEPTH || pop) q.push_back({CPADR[1:0], CPODT});
            else m_ovf = 1'b1;
         end
         n_total++; if (PSGWE !== exp_we) $display("FAIL rnd_psgwe cyc %0d got %b want %b", i, PSGWE, exp_we); else n_pass++;
         n_total++; if ({PSGSEL, PSGDT} !== exp_ent)
            $display("FAIL rnd_entry cyc %0d got %h want %h", i, {PSGSEL, PSGDT}, exp_ent); else n_pass++;
      end
      CE3M = 1'b0;
      read_byte(16'hA005, d);
      n_total++; if (d !== {m_ovf, 6'b0, 1'b1}) $display("FAIL rnd_status got %h want %h", d, {m_ovf, 6'b0, 1'b1}); else n_pass++;
   endtask

   task automatic test_mid_reset();
      int base;
      logic [7:0] d;
      do_reset();
      DSW1 = 8'h3E;
      bus_write(16'hA011, 8'h11, 2);
      bus_write(16'hA012, 8'h22, 2);
      bus_write(16'hA013, 8'h33, 2);
      bus_write(16'hA002, 8'h9A, 2);
      bus_write(16'hA004, 8'h01, 2);
      bus_write(16'hC805, 8'hE1, 1);
      read_byte(16'hA000, d);
      base = psg_obs.size();
      RESET = 1'b0; CE3M = 1'b1;
      step();
      n_total++; if ({CPIDT, SCRPX, SCRPY, FLIP} !== {8'hFF, SCR_RST_V, SCR_RST_V, 1'b0})
         $display("FAIL midrst_bus got %h want %h", {CPIDT, SCRPX, SCRPY, FLIP}, {8'hFF, SCR_RST_V, SCR_RST_V, 1'b0}); else n_pass++;
      n_total++; if ({PALWE, PALAD, PALDT, PSGWE, PSGSEL, PSGDT} !== 29'h0)
         $display("FAIL midrst_strobes got %h want 0", {PALWE, PALAD, PALDT, PSGWE, PSGSEL, PSGDT}); else n_pass++;
      step();
      RESET = 1'b1;
      step();
      n_total++; if (PSGWE !== 1'b0) $display("FAIL midrst_first_cycle got %b want 0", PSGWE); else n_pass++;
      repeat (4) step();
      CE3M = 1'b0;
      n_total++; if (psg_obs.size() != base) $display("FAIL midrst_pops got %0d want 0", psg_obs.size() - base); else n_pass++;
      read_byte(16'hA005, d);
      n_total++; if (d !== 8'h01) $display("FAIL midrst_status got %h want 01", d); else n_pass++;
      read_byte(16'hA002, d);
      n_total++; if (d !== SCR_RST_V) $display("FAIL midrst_shadow got %h want %h", d, SCR_RST_V); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_psg_single();
      test_overflow();
      test_scroll();
      test_pal();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
